// File: rtl/r_framer_param.sv
// rtl/r_framer_param.sv - parametrised serial deframer with sync search and hunt/check/lock FSM
//
// Optional feature macro: FRAMER_PARITY_EN (one even-parity bit appended after the payload).
//
// Ports:
//   clk        in   1       clock, all state on rising edge
//   rst        in   1       asynchronous active-low reset
//   data_in    in   1       serial bit, frame MSB (first sync bit) first
//   data_out   out  DATA_W  last accepted payload, held between frames
//   valid      out  1       one-cycle strobe, data_out is new
//   locked     out  1       high while in LOCK
//   correct    out  1       most recent LOCK boundary had good sync (and parity)
//   parity_err out  1       one-cycle strobe on payload parity failure (0 without macro)

module r_framer_param #(
    parameter int                DATA_W   = 12,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1010,
    parameter int                LOCK_CNT = 2,
    parameter int                LOSS_CNT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              locked,
    output logic              correct,
    output logic              parity_err
);

`ifdef FRAMER_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int FRAME_W = SYNC_W + DATA_W + PAR_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

    state_t              state, state_n;
    // Only FRAME_W-1 history bits are stored; the oldest bit of the window
    // is always the one shifted out this cycle, so it never needs a flop.
    logic [FRAME_W-2:0]  sr;
    logic [FRAME_W-1:0]  w;
    logic [CNT_W-1:0]    cnt;
    logic [GOOD_W-1:0]   good_cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic                match;
    logic                cnt_end;
    logic                boundary;
    logic                deliver;
    logic                miss;
    logic                loss;
    logic [DATA_W-1:0]   payload;
    logic                parity_ok;

    assign w       = {sr, data_in};
    assign match   = (w[FRAME_W-1 -: SYNC_W] == SYNC_PAT);
    assign cnt_end = (cnt == CNT_W'(FRAME_W - 1));

`ifdef FRAMER_PARITY_EN
    assign payload   = w[DATA_W:1];
    // Even parity: payload plus parity bit must hold an even number of ones.
    assign parity_ok = ~^w[DATA_W:0];
`else
    assign payload   = w[DATA_W-1:0];
    assign parity_ok = 1'b1;
`endif

    assign deliver = (state == LOCK) && cnt_end && match;
    assign miss    = (state == LOCK) && cnt_end && !match;
    assign loss    = miss && (int'(miss_cnt) + 1 == LOSS_CNT);
    assign locked  = (state == LOCK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= HUNT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        boundary = 1'b0;
        case (state)
            HUNT: begin
                boundary = match;
                if (match) begin
                    state_n = (LOCK_CNT == 1) ? LOCK : CHECK;
                end
            end
            CHECK: begin
                boundary = cnt_end;
                if (cnt_end) begin
                    if (!match) begin
                        state_n = HUNT;
                    end else if (int'(good_cnt) + 1 == LOCK_CNT) begin
                        state_n = LOCK;
                    end
                end
            end
            LOCK: begin
                boundary = cnt_end;
                if (loss) begin
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr         <= '0;
            cnt        <= '0;
            good_cnt   <= '0;
            miss_cnt   <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            correct    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            sr         <= w[FRAME_W-2:0];
            cnt        <= boundary ? '0 : cnt + CNT_W'(1);
            valid      <= deliver;
            parity_err <= deliver && !parity_ok;

            if (state == HUNT && match) begin
                good_cnt <= GOOD_W'(1);
            end else if (state == CHECK && cnt_end && match) begin
                good_cnt <= good_cnt + GOOD_W'(1);
            end

            if (deliver) begin
                data_out <= payload;
                correct  <= parity_ok;
                miss_cnt <= '0;
            end else if (miss) begin
                correct  <= 1'b0;
                miss_cnt <= loss ? '0 : miss_cnt + MISS_W'(1);
            end
        end
    end

endmodule

// File: doc/r_framer_param.md
Name: r_framer_param

Overview:
- Parametrised serial deframer; successor to the fixed 12-bit receive framer.
- Takes a 1-bit MSB-first stream of frames built as {SYNC_PAT, payload} and finds the frame boundary by sync search.
- Confirms lock with a hunt/check/lock state machine that tolerates sync misses.
- Delivers the DATA_W-bit payload with a one-cycle valid strobe; sits directly after the serial channel model, in front of data consumers.

Parameters:
- DATA_W, 12: payload bits per frame (>=1).
- SYNC_W, 4: sync header bits (>=2).
- SYNC_PAT, 4'b1010: sync header value, SYNC_W bits, must not be all-zero.
- LOCK_CNT, 2: consecutive matching boundaries needed to enter lock (>=1), counting the hunt match.
- LOSS_CNT, 3: consecutive sync misses in lock that drop lock (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset; when low, all state clears immediately.
- data_in  in  1  serial bit, one per clk; frame MSB (first sync bit) sent first.
- data_out  out  DATA_W  last accepted payload, held between frames.
- valid  out  1  one-cycle strobe; data_out is new.
- locked  out  1  high while in LOCK.
- correct  out  1  level; 1 when the most recent LOCK boundary had matching sync (and parity, if enabled).
- parity_err  out  1  one-cycle strobe on payload parity failure; tied 0 without macro.

Behaviour:
- FRAME_W = SYNC_W + DATA_W, plus 1 if FRAMER_PARITY_EN.
- Shift register sr[FRAME_W-1:0]: sr <= {sr[FRAME_W-2:0], data_in} every cycle.
- Window w = {sr[FRAME_W-2:0], data_in}, i.e. the last FRAME_W bits including the current one.
- match = (w[FRAME_W-1 -: SYNC_W] == SYNC_PAT).
- Bit counter cnt, width $clog2(FRAME_W):
  - Boundary cycle = cnt == FRAME_W-1 in CHECK/LOCK, or any match cycle in HUNT.
  - At a boundary cnt <= 0; otherwise cnt <= cnt+1.
- States: HUNT, CHECK, LOCK.
- HUNT: evaluate match every cycle. On match: good_cnt <= 1, cnt <= 0, next state CHECK (or LOCK directly if LOCK_CNT==1).
- CHECK, at each boundary:
  - match: good_cnt++; LOCK when good_cnt+1 == LOCK_CNT.
  - mismatch: HUNT, and search resumes on the next cycle.
  - No payload is delivered in CHECK.
- LOCK, at each boundary:
  - match: miss_cnt <= 0; data_out <= payload bits of w (w[DATA_W-1:0], or w[DATA_W:1] with parity); valid=1 and correct=1 the next cycle.
  - mismatch: miss_cnt++; correct <= 0; no valid; data_out held.
  - miss_cnt+1 == LOSS_CNT: HUNT, locked <= 0, miss_cnt <= 0.
- Latency: valid, data_out and correct are registered and change the cycle after the last frame bit is sampled.
- locked rises with entry to LOCK, before the first valid. correct is 0 outside LOCK.
- Sync pattern inside payload: HUNT may take it as a false candidate; CHECK rejects it at the next boundary. No valid is ever issued from an unconfirmed phase.
- Reset (rst low, async):
  - State HUNT; sr, cnt, good_cnt, miss_cnt all 0.
  - data_out=0, valid=0, locked=0, correct=0, parity_err=0.
  - Mid-frame reset discards the partial frame; after release, HUNT restarts at bit 0.

Optional Feature:
- Macro FRAMER_PARITY_EN.
- Defined:
  - Frame carries one even-parity bit after the payload (LSB of w), covering the payload bits.
  - At a LOCK boundary with matching sync: valid is issued. Bad parity also gives correct=0 and a one-cycle parity_err with valid.
  - Parity failure does not count as a sync miss.
- Undefined:
  - No parity bit; FRAME_W = SYNC_W + DATA_W.
  - parity_err constant 0.

Test Plan:
- Reset hold: rst=0 for 2 cycles with random data_in -> data_out=0, valid=0, locked=0, correct=0 throughout.
- Clean stream, defaults (FRAME_W=16), payloads 0x000,0x001,... starting mid-frame at bit 7:
  - locked rises at the second full-frame boundary.
  - First valid follows the third boundary, with data_out=payload of the third frame.
  - Then one valid every 16 cycles, incrementing by 1, correct=1.
- One corrupted sync (1010->1110) while locked -> that frame: no valid, correct=0, locked=1; next frame: valid with correct data, correct=1.
- Three consecutive corrupted syncs -> locked=0 after the third boundary. Clean frames then -> locked after 2 boundaries; valid resumes on the 3rd.
- Payload 0xA5A containing 1010, phase started inside the payload -> no valid carries misaligned data; lock lands on the true boundary.
- FRAMER_PARITY_EN, flip payload bit 3 of one frame -> valid=1, parity_err=1, correct=0 on that strobe; locked stays 1; next frame correct=1.
